// File: rtl/fetch_pc_unit.sv
// Instruction-fetch front end: owns the PC, issues in-order requests to
// instruction memory, queues returned words and feeds one per cycle to IF/ID.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned FQ_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] IM,
  output logic [31:0] PC,
  output logic        IF_flush,
  output logic        en
);

  localparam int unsigned PW = $clog2(FQ_DEPTH);
  localparam int unsigned CW = $clog2(FQ_DEPTH + 1);
  localparam logic [PW-1:0] PTR_ZERO   = {PW{1'b0}};
  localparam logic [PW-1:0] PTR_ONE    = PW'(1'b1);
  localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE    = CW'(1'b1);
  localparam logic [CW:0]   CREDIT_MAX = (CW+1)'(FQ_DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   issue_pc_q, issue_pc_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] fq_count_q, fq_count_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_count_q, drop_count_d;
  logic          started_q;
  logic [31:0]   fq_pc_q   [FQ_DEPTH];
  logic [31:0]   fq_inst_q [FQ_DEPTH];

  logic [CW:0]   inflight_s;
  logic          credit_s;
  logic          fq_empty_s;
  logic          req_valid_s;
  logic          issue_s;
  logic          drop_rsp_s;
  logic          push_s;
  logic          pop_s;
  logic [31:0]   redirect_aligned_s;
  logic [31:0]   head_pc_s;
  logic [31:0]   head_inst_s;

  // Requests in flight plus queued words may never exceed the queue size,
  // so every returning word is guaranteed a slot.
  assign inflight_s  = {1'b0, outstanding_q} + {1'b0, fq_count_q};
  assign credit_s    = (inflight_s < CREDIT_MAX);
  assign fq_empty_s  = (fq_count_q == CNT_ZERO);
  assign req_valid_s = rst_n && started_q && !redirect_valid && credit_s;
  assign issue_s     = req_valid_s && imem_req_ready;

  // A response is stale if a redirect happens now or one is still draining.
  assign drop_rsp_s  = imem_rsp_valid && (redirect_valid || (drop_count_q != CNT_ZERO));
  assign push_s      = imem_rsp_valid && !drop_rsp_s;
  assign pop_s       = !redirect_valid && !stall && !fq_empty_s;

  assign redirect_aligned_s = redirect_pc & 32'hFFFF_FFFC;
  assign head_pc_s          = fq_pc_q[head_q];
  assign head_inst_s        = fq_inst_q[head_q];

  assign imem_req_valid = req_valid_s;
  assign imem_req_addr  = fetch_pc_q;

  // Next-state for PC pointers, queue pointers and counters.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    issue_pc_d    = issue_pc_q;
    head_d        = head_q;
    tail_d        = tail_q;
    fq_count_d    = fq_count_q;
    drop_count_d  = drop_count_q;
    outstanding_d = outstanding_q;

    if (issue_s && !imem_rsp_valid) begin
      outstanding_d = outstanding_q + CNT_ONE;
    end else if (!issue_s && imem_rsp_valid) begin
      outstanding_d = outstanding_q - CNT_ONE;
    end else begin
      outstanding_d = outstanding_q;
    end

    if (redirect_valid) begin
      fetch_pc_d = redirect_aligned_s;
      issue_pc_d = redirect_aligned_s;
      head_d     = PTR_ZERO;
      tail_d     = PTR_ZERO;
      fq_count_d = CNT_ZERO;
      if (imem_rsp_valid) begin
        drop_count_d = outstanding_q - CNT_ONE;
      end else begin
        drop_count_d = outstanding_q;
      end
    end else begin
      if (issue_s) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end else begin
        fetch_pc_d = fetch_pc_q;
      end

      if (drop_rsp_s) begin
        drop_count_d = drop_count_q - CNT_ONE;
      end else begin
        drop_count_d = drop_count_q;
      end

      // Kept words arrive in issue order, so their PC is a second running pointer.
      if (push_s) begin
        tail_d     = tail_q + PTR_ONE;
        issue_pc_d = issue_pc_q + 32'd4;
      end else begin
        tail_d     = tail_q;
        issue_pc_d = issue_pc_q;
      end

      if (pop_s) begin
        head_d = head_q + PTR_ONE;
      end else begin
        head_d = head_q;
      end

      if (push_s && !pop_s) begin
        fq_count_d = fq_count_q + CNT_ONE;
      end else if (!push_s && pop_s) begin
        fq_count_d = fq_count_q - CNT_ONE;
      end else begin
        fq_count_d = fq_count_q;
      end
    end
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC;
      issue_pc_q    <= RESET_PC;
      head_q        <= PTR_ZERO;
      tail_q        <= PTR_ZERO;
      fq_count_q    <= CNT_ZERO;
      outstanding_q <= CNT_ZERO;
      drop_count_q  <= CNT_ZERO;
      started_q     <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      issue_pc_q    <= issue_pc_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      fq_count_q    <= fq_count_d;
      outstanding_q <= outstanding_d;
      drop_count_q  <= drop_count_d;
      started_q     <= 1'b1;
    end
  end

  // Queue storage; contents are only meaningful below fq_count_q.
  always_ff @(posedge clk) begin
    if (rst_n && push_s) begin
      fq_pc_q[tail_q]   <= issue_pc_q;
      fq_inst_q[tail_q] <= imem_rsp_data;
    end
  end

  // IF/ID slot selection: redirect kill, stall hold, queue head, or bubble.
  always_comb begin
    en       = 1'b0;
    IF_flush = 1'b0;
    IM       = 32'h0000_0000;
    PC       = 32'h0000_0000;
    if (!rst_n) begin
      en       = 1'b0;
      IF_flush = 1'b0;
    end else if (redirect_valid) begin
      en       = 1'b1;
      IF_flush = 1'b1;
    end else if (stall) begin
      en       = 1'b0;
      IF_flush = fq_empty_s;
      IM       = head_inst_s;
      PC       = head_pc_s;
    end else if (!fq_empty_s) begin
      en       = 1'b1;
      IF_flush = 1'b0;
      IM       = head_inst_s;
      PC       = head_pc_s;
    end else begin
      en       = 1'b1;
      IF_flush = 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: in-order memory with configurable latency, a
// queue-based reference model and an independent instruction-stream tracker.
module tb_fetch_pc_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int D = 2;

  logic        clk = 1'b0;
  logic        rst_n, imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic        stall, redirect_valid, IF_flush, en;
  logic [31:0] imem_req_addr, imem_rsp_data, redirect_pc, IM, PC;

  fetch_pc_unit #(.RESET_PC(RESET_PC), .FQ_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .IM(IM), .PC(PC), .IF_flush(IF_flush), .en(en)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] addr; logic [31:0] epoch; } req_t;
  typedef struct packed { logic [31:0] pc;   logic [31:0] inst;  } word_t;
  typedef struct packed { logic [31:0] addr; logic [31:0] due;   } mem_t;

  req_t  m_out[$];
  word_t m_fq[$];
  mem_t  memq[$];
  bit          m_started;
  logic [31:0] m_fetch;
  int          m_epoch, cyc, k_lat, last_due;
  logic [31:0] mem_key, stream_pc;
  int          errors, checks;
  bit          proto_bad;

  logic        exp_req_valid, exp_en, exp_flush;
  logic [31:0] exp_addr, exp_im, exp_pc;
  logic        obs_req_valid, obs_en, obs_flush;
  logic [31:0] obs_addr, obs_im, obs_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ mem_key;
  endfunction

  function automatic bit mem_fire();
    return (memq.size() > 0) && (int'(memq[0].due) <= cyc);
  endfunction

  // One clock: memory drives a response, expectations are formed, outputs are
  // sampled mid-cycle, then model and memory take the edge.
  task automatic tick();
    req_t r; word_t w; mem_t mm; int nd;
    if (rst_n && mem_fire()) begin
      imem_rsp_valid = 1'b1; imem_rsp_data = mem_word(memq[0].addr);
    end else begin
      imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    end
    exp_req_valid = 1'b0; exp_addr = m_fetch; exp_en = 1'b0; exp_flush = 1'b0;
    exp_im = 32'h0; exp_pc = 32'h0;
    proto_bad = rst_n && imem_rsp_valid && (m_fq.size() >= D);
    if (rst_n) begin
      exp_req_valid = m_started && !redirect_valid && (m_out.size() + m_fq.size() < D);
      if (redirect_valid) begin
        exp_en = 1'b1; exp_flush = 1'b1;
      end else if (stall) begin
        exp_en = 1'b0;
      end else if (m_fq.size() > 0) begin
        exp_en = 1'b1; exp_im = m_fq[0].inst; exp_pc = m_fq[0].pc;
      end else begin
        exp_en = 1'b1; exp_flush = 1'b1;
      end
    end
    @(negedge clk);
    obs_req_valid = imem_req_valid; obs_addr = imem_req_addr;
    obs_en = en; obs_flush = IF_flush; obs_im = IM; obs_pc = PC;
    if (!rst_n) begin
      m_started = 1'b0; m_fetch = RESET_PC;
      m_out.delete(); m_fq.delete(); memq.delete(); last_due = 0;
    end else begin
      if (!redirect_valid && !stall && m_fq.size() > 0) void'(m_fq.pop_front());
      if (imem_rsp_valid && m_out.size() > 0) begin
        r = m_out.pop_front();
        if (!redirect_valid && int'(r.epoch) == m_epoch) begin
          w.pc = r.addr; w.inst = mem_word(r.addr); m_fq.push_back(w);
        end
      end
      if (exp_req_valid && imem_req_ready) begin
        r.addr = m_fetch; r.epoch = 32'(m_epoch); m_out.push_back(r);
        m_fetch = m_fetch + 32'd4;
      end
      if (redirect_valid) begin
        m_epoch++; m_fq.delete(); m_fetch = {redirect_pc[31:2], 2'b00};
      end
      m_started = 1'b1;
      if (imem_rsp_valid) void'(memq.pop_front());
      if (obs_req_valid === 1'b1 && imem_req_ready) begin
        nd = cyc + k_lat;
        if (nd <= last_due) nd = last_due + 1;
        last_due = nd;
        mm.addr = obs_addr; mm.due = 32'(nd); memq.push_back(mm);
      end
    end
    cyc++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_req_ready = 1'b1;
    tick(); tick();
    checks++;
    if ({obs_req_valid, obs_en, obs_flush, obs_im, obs_pc} !== {3'b000, 32'h0, 32'h0}) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b en=%b fl=%b IM=%h PC=%h want all 0",
               obs_req_valid, obs_en, obs_flush, obs_im, obs_pc);
    end
    rst_n = 1'b1; stream_pc = RESET_PC;
    tick();
    checks++;
    if ({obs_req_valid, obs_en, obs_flush} !== 3'b011) begin
      errors++;
      $display("FAIL release_cycle: got v/en/fl=%b%b%b want 011", obs_req_valid, obs_en, obs_flush);
    end
  endtask

  task automatic test_stream();
    k_lat = 1;
    for (int i = 0; i < 14; i++) begin
      tick();
      checks++;
      if ({obs_req_valid, obs_en} !== {exp_req_valid, exp_en}) begin
        errors++; $display("FAIL stream_ctl: got v/en=%b%b want %b%b", obs_req_valid, obs_en, exp_req_valid, exp_en);
      end
      if (exp_req_valid) begin
        checks++;
        if (obs_addr !== exp_addr) begin errors++; $display("FAIL stream_addr: got %h want %h", obs_addr, exp_addr); end
      end
      if (exp_en) begin
        checks++;
        if ({obs_flush, obs_im, obs_pc} !== {exp_flush, exp_im, exp_pc}) begin
          errors++; $display("FAIL stream_slot: got fl=%b IM=%h PC=%h want fl=%b IM=%h PC=%h",
                             obs_flush, obs_im, obs_pc, exp_flush, exp_im, exp_pc);
        end
      end
      if (obs_en === 1'b1 && obs_flush === 1'b0) begin
        checks++;
        if (obs_pc !== stream_pc || obs_im !== mem_word(stream_pc)) begin
          errors++; $display("FAIL stream_order: got PC=%h IM=%h want PC=%h IM=%h", obs_pc, obs_im, stream_pc, mem_word(stream_pc));
        end
        stream_pc += 32'd4;
      end
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs_en !== 1'b0) begin errors++; $display("FAIL stall_en: got %b want 0", obs_en); end
      checks++;
      if (obs_req_valid !== exp_req_valid) begin
        errors++; $display("FAIL stall_credit: got v=%b want %b", obs_req_valid, exp_req_valid);
      end
    end
    stall = 1'b0;
    test_stream();
  endtask

  task automatic test_redirect();
    int guard;
    k_lat = 3;
    guard = 0;
    while (m_out.size() != 2 && guard < 40) begin tick(); guard++; end
    checks++;
    if (m_out.size() != 2) begin errors++; $display("FAIL redirect_setup: outstanding=%0d want 2", m_out.size()); end
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
    tick();
    checks++;
    if ({obs_en, obs_flush, obs_im, obs_pc} !== {2'b11, 32'h0, 32'h0}) begin
      errors++; $display("FAIL redirect_kill: got en=%b fl=%b IM=%h PC=%h want 1 1 0 0", obs_en, obs_flush, obs_im, obs_pc);
    end
    redirect_valid = 1'b0; stream_pc = 32'h0000_0100;
    guard = 0;
    while (!(obs_en === 1'b1 && obs_flush === 1'b0) && guard < 30) begin tick(); guard++; end
    checks++;
    if (obs_en !== 1'b1 || obs_flush !== 1'b0 || obs_pc !== 32'h0000_0100) begin
      errors++; $display("FAIL redirect_target: got en=%b fl=%b PC=%h want valid PC 00000100", obs_en, obs_flush, obs_pc);
    end
    stream_pc = 32'h0000_0104;
    test_stream();
  endtask

  task automatic test_redirect_stall_rsp();
    int guard;
    k_lat = 2;
    guard = 0;
    while (!(m_out.size() == 2 && mem_fire()) && guard < 40) begin tick(); guard++; end
    checks++;
    if (!(m_out.size() == 2 && mem_fire())) begin errors++; $display("FAIL rsr_setup: outstanding=%0d want 2 with rsp", m_out.size()); end
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0203;
    tick();
    checks++;
    if ({obs_en, obs_flush, obs_im, obs_pc} !== {2'b11, 32'h0, 32'h0}) begin
      errors++; $display("FAIL rsr_kill: got en=%b fl=%b IM=%h PC=%h want 1 1 0 0", obs_en, obs_flush, obs_im, obs_pc);
    end
    stall = 1'b0; redirect_valid = 1'b0; stream_pc = 32'h0000_0200;
    tick();
    checks++;
    if (obs_req_valid !== 1'b1 || obs_addr !== 32'h0000_0200) begin
      errors++; $display("FAIL rsr_next_req: got v=%b addr=%h want 1 00000200", obs_req_valid, obs_addr);
    end
    guard = 0;
    while (!(obs_en === 1'b1 && obs_flush === 1'b0) && guard < 30) begin tick(); guard++; end
    checks++;
    if (obs_en !== 1'b1 || obs_flush !== 1'b0 || obs_pc !== 32'h0000_0200) begin
      errors++; $display("FAIL rsr_target: got en=%b fl=%b PC=%h want valid PC 00000200", obs_en, obs_flush, obs_pc);
    end
    stream_pc = 32'h0000_0204;
  endtask

  task automatic test_ready_low();
    int guard;
    logic [31:0] saved;
    guard = 0;
    while (!(m_started && (m_out.size() + m_fq.size() < D)) && guard < 20) begin tick(); guard++; end
    imem_req_ready = 1'b0; saved = m_fetch;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (obs_req_valid !== 1'b1 || obs_addr !== saved) begin
        errors++; $display("FAIL ready_low_hold: got v=%b addr=%h want 1 %h", obs_req_valid, obs_addr, saved);
      end
      if (obs_en === 1'b1 && obs_flush === 1'b0) stream_pc += 32'd4;
    end
    checks++;
    if ({obs_en, obs_flush} !== 2'b11) begin
      errors++; $display("FAIL ready_low_bubble: got en/fl=%b%b want 11", obs_en, obs_flush);
    end
    imem_req_ready = 1'b1;
    test_stream();
  endtask

  task automatic test_mid_reset();
    rst_n = 1'b0;
    tick();
    checks++;
    if ({obs_req_valid, obs_en, obs_flush, obs_im, obs_pc} !== {3'b000, 32'h0, 32'h0}) begin
      errors++; $display("FAIL midreset_outputs: got v=%b en=%b fl=%b IM=%h PC=%h want all 0",
                         obs_req_valid, obs_en, obs_flush, obs_im, obs_pc);
    end
    rst_n = 1'b1; mem_key = 32'h5A5A_0000; stream_pc = RESET_PC;
    tick(); tick();
    checks++;
    if (obs_req_valid !== 1'b1 || obs_addr !== RESET_PC) begin
      errors++; $display("FAIL midreset_restart: got v=%b addr=%h want 1 %h", obs_req_valid, obs_addr, RESET_PC);
    end
    test_stream();
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      if (i % 100 == 0) k_lat = $urandom_range(3, 1);
      imem_req_ready = ($urandom_range(3, 0) != 0);
      stall          = ($urandom_range(3, 0) == 0);
      redirect_valid = ($urandom_range(15, 0) == 0);
      redirect_pc    = $urandom() & 32'h0000_3FFF;
      tick();
      checks++;
      if ({obs_req_valid, obs_en} !== {exp_req_valid, exp_en}) begin
        errors++; $display("FAIL rand_ctl @%0d: got v/en=%b%b want %b%b", cyc, obs_req_valid, obs_en, exp_req_valid, exp_en);
      end
      if (exp_req_valid) begin
        checks++;
        if (obs_addr !== exp_addr) begin errors++; $display("FAIL rand_addr @%0d: got %h want %h", cyc, obs_addr, exp_addr); end
      end
      if (exp_en) begin
        checks++;
        if ({obs_flush, obs_im, obs_pc} !== {exp_flush, exp_im, exp_pc}) begin
          errors++; $display("FAIL rand_slot @%0d: got fl=%b IM=%h PC=%h want fl=%b IM=%h PC=%h",
                             cyc, obs_flush, obs_im, obs_pc, exp_flush, exp_im, exp_pc);
        end
      end
      if (obs_en === 1'b1 && obs_flush === 1'b0) begin
        checks++;
        if (obs_pc !== stream_pc || obs_im !== mem_word(stream_pc)) begin
          errors++; $display("FAIL rand_order @%0d: got PC=%h want %h", cyc, obs_pc, stream_pc);
        end
        stream_pc += 32'd4;
      end
      checks++;
      if (proto_bad) begin errors++; $display("FAIL rand_fq_overflow @%0d: rsp with fq full got 1 want 0", cyc); end
      if (redirect_valid) stream_pc = {redirect_pc[31:2], 2'b00};
    end
    redirect_valid = 1'b0; stall = 1'b0; imem_req_ready = 1'b1;
  endtask

  initial begin
    errors = 0; checks = 0; cyc = 0; last_due = 0; m_epoch = 0;
    k_lat = 1; mem_key = 32'h0; stream_pc = RESET_PC;
    m_started = 1'b0; m_fetch = RESET_PC;
    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    @(posedge clk); #1;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_stall_rsp();
    test_ready_low();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
